// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes a framed serial sample stream into
// per-channel output registers with per-channel valid strobes.
module tdm_demux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      frame_start,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CW-1:0]             chan,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_err
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_t                    state, state_nx;
  logic [CW-1:0]             chan_nx;
  logic [CHANNELS*WIDTH-1:0] data_nx;
  logic [CHANNELS-1:0]       valid_nx;
  logic                      done_nx, err_nx;
  logic                      store;
  logic [CW-1:0]             slot;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx = state;
    chan_nx  = chan;
    data_nx  = out_data;
    valid_nx = '0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    store    = 1'b0;
    slot     = '0;

    if (in_valid) begin
      if (frame_start) begin
        // A start inside a frame abandons the partial frame and is flagged.
        err_nx   = (state == RECV);
        store    = 1'b1;
        slot     = '0;
        chan_nx  = CW'(1);
        state_nx = RECV;
      end else if (state == IDLE) begin
        err_nx = 1'b1;
      end else begin
        store = 1'b1;
        slot  = chan;
        if (chan == LAST) begin
          done_nx  = 1'b1;
          chan_nx  = '0;
          state_nx = IDLE;
        end else begin
          chan_nx = CW'(chan + 1'b1);
        end
      end
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (store && slot == CW'(k)) begin
        data_nx[k*WIDTH +: WIDTH] = in_data;
        valid_nx[k]               = 1'b1;
      end
    end
  end

  // NOTE: the channel registers are plain flops, not a RAM, so clearing them on reset is cheap and required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chan       <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      chan       <= chan_nx;
      out_data   <= data_nx;
      out_valid  <= valid_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed vector table, hand-written
// gap/reset sequences and randomized traffic against a behavioural model.
module tb_tdm_demux;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int CW       = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [WIDTH-1:0]          in_data;
  logic                      in_valid;
  logic                      frame_start;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CW-1:0]             chan;
  logic                      busy;
  logic                      frame_done;
  logic                      frame_err;

  tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .frame_start(frame_start), .out_data(out_data), .out_valid(out_valid),
    .chan(chan), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        fs;
    logic [3:0]  d;
    logic [15:0] e_data;
    logic [3:0]  e_valid;
    logic [1:0]  e_chan;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: channel contents plus frame position.
  int m_ch[CHANNELS];
  bit m_in_frame;
  int m_pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d, input logic [3:0] v,
                           input logic [1:0] c, input logic b, input logic dn, input logic er);
    check({tag, ".out_data"},   32'(out_data),   32'(d));
    check({tag, ".out_valid"},  32'(out_valid),  32'(v));
    check({tag, ".chan"},       32'(chan),       32'(c));
    check({tag, ".busy"},       32'(busy),       32'(b));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(dn));
    check({tag, ".frame_err"},  32'(frame_err),  32'(er));
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic fs, input logic [3:0] d);
    @(negedge clk);
    in_valid    = v;
    frame_start = fs;
    in_data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; in_data = '0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    m_in_frame = 1'b0;
    m_pos      = 0;
    for (int k = 0; k < CHANNELS; k++) m_ch[k] = 0;
  endtask

  function automatic logic [15:0] model_data();
    int acc = 0;
    for (int k = 0; k < CHANNELS; k++) acc += m_ch[k] * (1 << (WIDTH * k));
    return acc[15:0];
  endfunction

  task automatic model_step(input logic v, input logic fs, input logic [3:0] d,
                            output logic [3:0] ev, output logic edn, output logic eer);
    ev = '0; edn = 1'b0; eer = 1'b0;
    if (v) begin
      if (fs) begin
        eer = m_in_frame;
        m_ch[0] = d; ev = 4'b0001; m_in_frame = 1'b1; m_pos = 1;
      end else if (!m_in_frame) begin
        eer = 1'b1;
      end else begin
        m_ch[m_pos] = d; ev = 4'(1 << m_pos); m_pos++;
        if (m_pos == CHANNELS) begin
          edn = 1'b1; m_in_frame = 1'b0; m_pos = 0;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] ev;
    logic       edn, eer;
    logic       v, fs;
    logic [3:0] d;
    int         gap;

    rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; in_data = '0;
    #2;
    check_all("reset", 16'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame, error from IDLE, mid-frame restart, back-to-back frames.
    vecs = '{
      '{1,1,4'h1,16'h0001,4'b0001,1,1,0,0}, '{1,0,4'h2,16'h0021,4'b0010,2,1,0,0},
      '{1,0,4'h3,16'h0321,4'b0100,3,1,0,0}, '{1,0,4'h4,16'h4321,4'b1000,0,0,1,0},
      '{0,0,4'h9,16'h4321,4'b0000,0,0,0,0}, '{1,0,4'hF,16'h4321,4'b0000,0,0,0,1},
      '{0,0,4'h0,16'h4321,4'b0000,0,0,0,0}, '{1,1,4'hA,16'h432A,4'b0001,1,1,0,0},
      '{1,0,4'hB,16'h43BA,4'b0010,2,1,0,0}, '{1,1,4'hC,16'h43BC,4'b0001,1,1,0,1},
      '{1,0,4'hD,16'h43DC,4'b0010,2,1,0,0}, '{1,0,4'hE,16'h4EDC,4'b0100,3,1,0,0},
      '{1,0,4'hF,16'hFEDC,4'b1000,0,0,1,0}, '{1,1,4'h1,16'hFED1,4'b0001,1,1,0,0},
      '{1,0,4'h2,16'hFE21,4'b0010,2,1,0,0}, '{1,0,4'h3,16'hF321,4'b0100,3,1,0,0},
      '{1,0,4'h4,16'h4321,4'b1000,0,0,1,0}, '{1,1,4'h5,16'h4325,4'b0001,1,1,0,0},
      '{1,0,4'h6,16'h4365,4'b0010,2,1,0,0}, '{1,0,4'h7,16'h4765,4'b0100,3,1,0,0},
      '{1,0,4'h8,16'h8765,4'b1000,0,0,1,0}, '{0,1,4'h3,16'h8765,4'b0000,0,0,0,0}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].fs, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                vecs[i].e_chan, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end

    // Frame with 1-3 idle cycles between samples: chan holds, no pulses.
    for (int s = 0; s < CHANNELS; s++) begin
      step(1'b1, s == 0, 4'(s + 1));
      check($sformatf("gap%0d.valid", s), 32'(out_valid), 32'(1 << s));
      gap = 1 + (s % 3);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 4'hA);
        check_all($sformatf("gap%0d_%0d", s, g), out_data, 4'h0,
                  2'((s + 1) % CHANNELS), s != CHANNELS - 1, 1'b0, 1'b0);
      end
    end
    check("gap.final_data", 32'(out_data), 32'h4321);

    // Asynchronous reset in the middle of a frame, seen before any edge.
    step(1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b0, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h8);
    check_all("post_rst", 16'h8765, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = m_in_frame ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      d  = 4'($urandom);
      model_step(v, fs, d, ev, edn, eer);
      step(v, fs, d);
      check_all($sformatf("rnd%0d", i), model_data(), ev, 2'(m_pos),
                m_in_frame, edn, eer);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
